dsm_decimator: RTL and testbench
================================

DSM_DECIMATOR -- requirements
Module: dsm_decimator

Interface
REQ-001 SHALL have parameter DECIM_LOG2, default 8, meaning log2 of the decimation ratio R (legal 8..12).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic rises on posedge clk.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset, sampled only on posedge clk.
REQ-004 SHALL have port insignal, input, 1, the delta-sigma bitstream: 1 means +1, 0 means -1.
REQ-005 SHALL have port en, input, 1, bit-qualify; insignal is consumed only on cycles with en=1.
REQ-006 SHALL have port data_out, output, 16, the signed two's-complement PCM sample.
REQ-007 SHALL have port wrreq, output, 1, a one-cycle pulse marking a new data_out.
REQ-008 SHALL have port sat, output, 1, a sticky flag set when any emitted sample was clipped.

Function
REQ-009 SHALL implement a 2nd-order CIC (sinc^2) decimator: two integrators at bit rate, two combs (differential delay 1) at output rate.
REQ-010 SHALL set internal width W = 2*DECIM_LOG2+2 bits; integrators and combs SHALL wrap modulo 2^W with no saturation.
REQ-011 SHALL advance the integrators and the phase counter only on cycles with en=1; with en=0 all state SHALL hold.
REQ-012 SHALL count accepted bits 0..R-1 with the phase counter, wrapping to 0 after R-1.
REQ-013 SHALL capture the second-integrator value (including the current bit) into the comb input on the cycle the R-th bit is accepted.
REQ-014 SHALL compute the combs in the following cycle; wrreq SHALL assert exactly 2 clk after the accepting edge, independent of en.
REQ-015 SHALL scale comb output y (range -R^2..+R^2) by arithmetic right shift of 2*DECIM_LOG2-15 bits (floor), then saturate to -32768..32767.
REQ-016 SHALL set sat=1 on any wrreq cycle whose pre-saturation value exceeded the range; sat SHALL clear only on reset.
REQ-017 SHALL hold data_out stable between wrreq pulses.
REQ-018 SHALL use states FILL and RUN: after reset FILL; the first 2 decimated results SHALL be discarded (no wrreq, data_out and sat unchanged); the third result SHALL move to RUN and emit.
REQ-019 SHALL in RUN emit one wrreq per R accepted bits; FILL->RUN is the only transition other than reset.
REQ-020 SHALL never assert wrreq on two consecutive cycles (guaranteed since R>=256).

Reset
REQ-021 SHALL, on reset=1 at posedge clk, clear integrators, comb delays, phase counter, data_out=0, wrreq=0, sat=0, state=FILL.
REQ-022 SHALL give reset priority over en and any pending capture; a result in flight when reset asserts SHALL NOT produce wrreq.
REQ-023 SHALL produce deterministic output independent of insignal/en values during reset.

Verification
REQ-024 SHALL verify: R=256, en=1, insignal constant 1 -> first wrreq at accepted bit 768 +2 clk, data_out=32767, sat=1.
REQ-025 SHALL verify: insignal constant 0 -> data_out=-32768 on every RUN wrreq, sat=0.
REQ-026 SHALL verify: alternating 1,0 -> data_out=0 on every RUN wrreq; wrreq period exactly 256 clk.
REQ-027 SHALL verify: repeating 1,1,1,0 -> data_out=16384 in RUN; repeating 1,0,0,0 -> -16384.
REQ-028 SHALL verify: en toggled 1,0 each cycle with constant 1 -> wrreq period 512 clk, values identical to REQ-024.
REQ-029 SHALL verify: reset pulsed mid-frame in RUN -> wrreq, data_out, sat all 0 next cycle; next wrreq only after 768 further accepted bits.

Source files
------------

// File: rtl/dsm_if.sv
// Bitstream-in / PCM-out bundle for the delta-sigma decimator.
// The decimator takes the slave modport and the bitstream source takes the master modport.
interface dsm_if;
    logic               insignal;
    logic               en;
    logic signed [15:0] data_out;
    logic               wrreq;
    logic               sat;

    modport master (
        output insignal,
        output en,
        input  data_out,
        input  wrreq,
        input  sat
    );

    modport slave (
        input  insignal,
        input  en,
        output data_out,
        output wrreq,
        output sat
    );
endinterface

// File: rtl/dsm_decimator.sv
// Second-order CIC (sinc^2) decimator turning a 1-bit delta-sigma stream into 16-bit PCM.
// Integrators run at bit rate, combs run at output rate, and the first two results are discarded.
module dsm_decimator #(
    parameter int unsigned DECIM_LOG2 = 8
) (
    input logic   clk,
    input logic   reset,
    dsm_if.slave  bus
);

    localparam int unsigned W     = 2 * DECIM_LOG2 + 2;
    localparam int unsigned SHIFT = 2 * DECIM_LOG2 - 15;

    localparam logic signed [W-1:0] PCM_MAX = W'(32767);
    localparam logic signed [W-1:0] PCM_MIN = W'(-32768);

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic signed [W-1:0] step;
    logic signed [W-1:0] int1_q, int1_d;
    logic signed [W-1:0] int2_q, int2_d;
    logic [DECIM_LOG2-1:0] phase_q;

    logic signed [W-1:0] comb_in_q, dly1_q, dly2_q, comb1, comb2;
    logic signed [W-1:0] y_q, y_shift;
    logic                cap_vld_q, y_vld_q;

    logic [0:0] state_q;
    logic [1:0] fill_cnt_q;

    logic signed [15:0] pcm;
    logic               clip;

    always_comb begin
        step    = bus.insignal ? W'(1) : {W{1'b1}};
        int1_d  = int1_q + step;
        int2_d  = int2_q + int1_d;
        comb1   = comb_in_q - dly1_q;
        comb2   = comb1 - dly2_q;
        // Arithmetic shift floors toward minus infinity.
        y_shift = y_q >>> SHIFT;
        pcm     = y_shift[15:0];
        clip    = 1'b0;
        if (y_shift > PCM_MAX) begin
            pcm  = 16'sh7fff;
            clip = 1'b1;
        end else if (y_shift < PCM_MIN) begin
            pcm  = 16'sh8000;
            clip = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            int1_q       <= '0;
            int2_q       <= '0;
            phase_q      <= '0;
            comb_in_q    <= '0;
            dly1_q       <= '0;
            dly2_q       <= '0;
            y_q          <= '0;
            cap_vld_q    <= 1'b0;
            y_vld_q      <= 1'b0;
            state_q      <= FILL;
            fill_cnt_q   <= 2'd0;
            bus.data_out <= '0;
            bus.wrreq    <= 1'b0;
            bus.sat      <= 1'b0;
        end else begin
            cap_vld_q <= 1'b0;
            y_vld_q   <= 1'b0;
            bus.wrreq <= 1'b0;

            if (bus.en) begin
                int1_q  <= int1_d;
                int2_q  <= int2_d;
                phase_q <= phase_q + 1'b1;
                // The R-th accepted bit closes the frame, including this bit's contribution.
                if (phase_q == '1) begin
                    comb_in_q <= int2_d;
                    cap_vld_q <= 1'b1;
                end
            end

            if (cap_vld_q) begin
                dly1_q  <= comb_in_q;
                dly2_q  <= comb1;
                y_q     <= comb2;
                y_vld_q <= 1'b1;
            end

            // The first two results see partially filled comb delays, so they are dropped.
            if (y_vld_q) begin
                if (state_q == FILL && fill_cnt_q != 2'd2) begin
                    fill_cnt_q <= fill_cnt_q + 2'd1;
                end else begin
                    state_q      <= RUN;
                    bus.wrreq    <= 1'b1;
                    bus.data_out <= pcm;
                    if (clip) begin
                        bus.sat <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dsm_decimator.sv
// Scoreboard bench for dsm_decimator: a direct triangular-FIR model predicts each emitted sample,
// its sticky saturation flag and the cycle its wrreq must appear on.
module tb_dsm_decimator;

    localparam int unsigned L  = 8;
    localparam int          R  = 1 << L;
    localparam int          SH = 2 * L - 15;

    typedef struct {
        int     val;
        bit     sat;
        longint cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    dsm_if bus ();

    dsm_decimator #(.DECIM_LOG2(L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t   sbq[$];
    int     n_checks = 0;
    int     n_errors = 0;
    longint cyc = 0;
    int     wr_count = 0;
    longint last_wr_cyc = 0;
    longint last_period = 0;
    int     hist[1024];
    int     nb = 0;
    int     nres = 0;
    bit     m_sat = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Sinc^2 as a FIR: triangular weights 1..R..1 over the last 2R-1 bits.
    function automatic int cic_model();
        int y = 0;
        for (int k = 0; k < 2 * R - 1; k++) begin
            int idx;
            int w;
            idx = nb - 1 - k;
            w   = (k < R) ? k + 1 : 2 * R - 1 - k;
            if (idx >= 0) y += w * hist[idx % 1024];
        end
        return y;
    endfunction

    task automatic push_expected();
        int y;
        int s;
        int v;
        y = cic_model();
        s = y >>> SH;
        v = s;
        if (s > 32767) begin
            v     = 32767;
            m_sat = 1'b1;
        end else if (s < -32768) begin
            v     = -32768;
            m_sat = 1'b1;
        end
        // Accepting edge is the next posedge; wrreq is seen at the negedge two edges later.
        sbq.push_back('{v, m_sat, cyc + 3});
    endtask

    task automatic drive(input bit b, input bit e);
        @(posedge clk);
        #2;
        bus.insignal = b;
        bus.en       = e;
        if (e) begin
            hist[nb % 1024] = b ? 1 : -1;
            nb++;
            if (nb % R == 0) begin
                nres++;
                if (nres > 2) push_expected();
            end
        end
    endtask

    task automatic run(input int nbits, input logic [3:0] pat, input int plen, input bit toggle_en);
        for (int i = 0; i < nbits; i++) begin
            drive(pat[i % plen], 1'b1);
            if (toggle_en) drive(1'($urandom), 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'($urandom), 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset        = 1'b1;
        bus.en       = 1'($urandom);
        bus.insignal = 1'($urandom);
        @(posedge clk);
        #2;
        sbq.delete();
        nb     = 0;
        nres   = 0;
        m_sat  = 1'b0;
        reset  = 1'b0;
        bus.en = 1'b0;
        check_eq("rst_wrreq", bus.wrreq, 0);
        check_eq("rst_data", $signed(bus.data_out), 0);
        check_eq("rst_sat", bus.sat, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
            check_eq("missed_wrreq", 0, 1);
            void'(sbq.pop_front());
        end
        if (bus.wrreq === 1'b1) begin
            wr_count++;
            last_period = cyc - last_wr_cyc;
            last_wr_cyc = cyc;
            if (sbq.size() == 0) begin
                check_eq("spurious_wrreq", 1, 0);
            end else begin
                e = sbq.pop_front();
                check_eq("data", $signed(bus.data_out), e.val);
                check_eq("sat", bus.sat, e.sat);
                check_eq("wr_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int w0;
        reset        = 1'b1;
        bus.en       = 1'b0;
        bus.insignal = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("init_wrreq", bus.wrreq, 0);
        check_eq("init_data", $signed(bus.data_out), 0);
        check_eq("init_sat", bus.sat, 0);
        reset = 1'b0;

        run(5 * R, 4'b1111, 1, 1'b0);
        idle(4);
        check_eq("ones_data", $signed(bus.data_out), 32767);
        check_eq("ones_sat", bus.sat, 1);

        do_reset();
        run(5 * R, 4'b0000, 1, 1'b0);
        idle(4);
        check_eq("zeros_data", $signed(bus.data_out), -32768);
        check_eq("zeros_sat", bus.sat, 0);

        do_reset();
        run(5 * R, 4'b0001, 2, 1'b0);
        idle(4);
        check_eq("alt_data", $signed(bus.data_out), 0);
        check_eq("alt_period", last_period, 256);

        do_reset();
        run(5 * R, 4'b0111, 4, 1'b0);
        idle(4);
        check_eq("p1110_data", $signed(bus.data_out), 16384);

        do_reset();
        run(5 * R, 4'b0001, 4, 1'b0);
        idle(4);
        check_eq("p1000_data", $signed(bus.data_out), -16384);

        do_reset();
        run(5 * R, 4'b1111, 1, 1'b1);
        idle(4);
        check_eq("toggle_data", $signed(bus.data_out), 32767);
        check_eq("toggle_sat", bus.sat, 1);
        check_eq("toggle_period", last_period, 512);

        // Reset mid-frame while in RUN, then require a full refill of 768 bits.
        do_reset();
        run(4 * R + 100, 4'b0111, 4, 1'b0);
        do_reset();
        w0 = wr_count;
        run(3 * R - 1, 4'b0111, 4, 1'b0);
        idle(4);
        check_eq("pre_768_count", wr_count - w0, 0);
        run(1, 4'b0111, 4, 1'b0);
        idle(4);
        check_eq("post_768_count", wr_count - w0, 1);

        // Reset lands while the first RUN result is still in the comb pipeline.
        do_reset();
        w0 = wr_count;
        run(3 * R, 4'b1111, 1, 1'b0);
        do_reset();
        idle(6);
        check_eq("inflight_count", wr_count - w0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
